// File: rtl/ntr_response_tx.sv
// rtl/ntr_response_tx.sv - NTR cartridge bus response transmitter (word-to-byte serialiser)
//
// Takes 32-bit little-endian words from an upstream source and presents them
// one byte at a time on the NTR data bus, advancing on each falling edge of the
// host bus clock (ntr_clk), which is synchronised into the clk domain.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   ntr_clk         host bus clock, asynchronous to clk
//   start, len      one-cycle start pulse and response length in bytes
//   abort           host deselect, cancels any transfer in progress
//   word_data/valid/ready  upstream word handshake
//   ntr_dout, ntr_oe       byte and pad output enable for the NTR data bus
//   busy, done, underrun   status: not idle, completion pulse, sticky starvation flag
module ntr_response_tx #(
    parameter int LEN_W       = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ntr_clk,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic [31:0]      word_data,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [7:0]       ntr_dout,
    output logic             ntr_oe,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t                 state_q, state_n;
    logic [SYNC_STAGES-1:0] ntr_sync_q;
    logic                   ntr_hist_q;
    logic                   fe;

    logic [LEN_W-1:0]       rem_q, rem_n;
    logic [1:0]             idx_q, idx_n;
    logic [31:0]            cur_q, cur_n;
    logic                   cur_valid_q, cur_valid_n;
    logic [31:0]            pf_q, pf_n;
    logic                   pf_full_q, pf_full_n;
    logic [7:0]             dout_n;
    logic                   oe_n;
    logic                   done_n;
    logic                   under_n;

    logic [2:0]             left_in_word;
    logic                   need_more;

    // Falling edge of the synchronised host clock.
    assign fe   = ntr_hist_q & ~ntr_sync_q[SYNC_STAGES-1];
    assign busy = (state_q != S_IDLE);

    // A further word is only wanted if the transfer extends past the bytes
    // still left in the current word.
    assign left_in_word = 3'd4 - {1'b0, idx_q};
    assign need_more    = rem_q > {{(LEN_W-3){1'b0}}, left_in_word};

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ntr_sync_q  <= '0;
            ntr_hist_q  <= 1'b0;
            rem_q       <= '0;
            idx_q       <= 2'd0;
            cur_q       <= 32'h0;
            cur_valid_q <= 1'b0;
            pf_q        <= 32'h0;
            pf_full_q   <= 1'b0;
            ntr_dout    <= 8'hFF;
            ntr_oe      <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_n;
            ntr_sync_q  <= {ntr_sync_q[SYNC_STAGES-2:0], ntr_clk};
            ntr_hist_q  <= ntr_sync_q[SYNC_STAGES-1];
            rem_q       <= rem_n;
            idx_q       <= idx_n;
            cur_q       <= cur_n;
            cur_valid_q <= cur_valid_n;
            pf_q        <= pf_n;
            pf_full_q   <= pf_full_n;
            ntr_dout    <= dout_n;
            ntr_oe      <= oe_n;
            done        <= done_n;
            underrun    <= under_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        rem_n       = rem_q;
        idx_n       = idx_q;
        cur_n       = cur_q;
        cur_valid_n = cur_valid_q;
        pf_n        = pf_q;
        pf_full_n   = pf_full_q;
        dout_n      = ntr_dout;
        oe_n        = ntr_oe;
        done_n      = 1'b0;
        under_n     = underrun;
        word_ready  = 1'b0;

        if (abort && state_q != S_IDLE) begin
            // Deselect wins over any edge or handshake in the same cycle;
            // word_ready stays low so no word is silently swallowed.
            state_n   = S_IDLE;
            oe_n      = 1'b0;
            dout_n    = 8'hFF;
            pf_full_n = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    oe_n   = 1'b0;
                    dout_n = 8'hFF;
                    if (start) begin
                        under_n   = 1'b0;
                        pf_full_n = 1'b0;
                        idx_n     = 2'd0;
                        if (len == '0) begin
                            done_n = 1'b1;
                        end else begin
                            rem_n   = len;
                            state_n = S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    word_ready = 1'b1;
                    if (word_valid) begin
                        cur_n       = word_data;
                        cur_valid_n = 1'b1;
                        idx_n       = 2'd0;
                        dout_n      = word_data[7:0];
                        oe_n        = 1'b1;
                        state_n     = S_DRIVE;
                    end
                end

                S_DRIVE: begin
                    word_ready = ~pf_full_q & need_more;
                    if (word_valid && word_ready) begin
                        pf_n      = word_data;
                        pf_full_n = 1'b1;
                    end
                    if (fe) begin
                        rem_n = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_n   = S_DONE;
                            oe_n      = 1'b0;
                            dout_n    = 8'hFF;
                            pf_full_n = 1'b0;
                            done_n    = 1'b1;
                        end else if (idx_q != 2'd3) begin
                            idx_n  = idx_q + 2'd1;
                            dout_n = cur_valid_q ? pick_byte(cur_q, idx_q + 2'd1) : 8'hFF;
                        end else begin
                            idx_n = 2'd0;
                            if (pf_full_q) begin
                                cur_n       = pf_q;
                                cur_valid_n = 1'b1;
                                pf_full_n   = 1'b0;
                                dout_n      = pf_q[7:0];
                            end else begin
                                // Starved: pad with FF and keep counting host
                                // cycles; a late word waits for the next word
                                // boundary so byte alignment is preserved.
                                cur_valid_n = 1'b0;
                                dout_n      = 8'hFF;
                                under_n     = 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_n   = S_IDLE;
                    oe_n      = 1'b0;
                    dout_n    = 8'hFF;
                    pf_full_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntr_response_tx.sv
// tb/tb_ntr_response_tx.sv - directed self-checking bench for ntr_response_tx
module tb_ntr_response_tx;

    localparam int LEN_W = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             ntr_clk = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic [31:0]      word_data = 32'h0;
    logic             word_valid = 1'b0;
    logic             word_ready;
    logic [7:0]       ntr_dout;
    logic             ntr_oe;
    logic             busy;
    logic             done;
    logic             underrun;

    ntr_response_tx #(.LEN_W(LEN_W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ntr_clk    (ntr_clk),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .ntr_dout   (ntr_dout),
        .ntr_oe     (ntr_oe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    // clk posedges at 5+10k; ntr_clk edges at 2+80k, never coinciding.
    always #5 clk = ~clk;
    initial begin
        #2;
        forever #80 ntr_clk = ~ntr_clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] src_q[$];
    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];
    int          done_cnt = 0;
    int          done_at  = -1;
    int          hs_cnt   = 0;
    int          hs2_at   = -1;
    bit          oe_seen  = 1'b0;
    bit          pending_pop = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upstream word source plus cycle-level monitors.
    always @(negedge clk) begin
        if (pending_pop && src_q.size() > 0) void'(src_q.pop_front());
        pending_pop = 1'b0;
        word_valid  = (src_q.size() > 0);
        word_data   = (src_q.size() > 0) ? src_q[0] : 32'h0;
        #1;
        if (word_valid && word_ready) begin
            pending_pop = 1'b1;
            hs_cnt++;
            if (hs_cnt == 2) hs2_at = cap_q.size();
        end
        if (done) begin
            done_cnt++;
            done_at = cap_q.size();
        end
        if (ntr_oe) oe_seen = 1'b1;
    end

    // Host side: bytes are sampled on the rising edge of ntr_clk.
    always @(posedge ntr_clk) begin
        if (ntr_oe === 1'b1) cap_q.push_back(ntr_dout);
    end

    task automatic do_start(input logic [LEN_W-1:0] n);
        @(negedge ntr_clk);
        repeat (3) @(negedge clk);
        len   = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_bytes(input string tag);
        logic [31:0] got;
        check({tag, "_nbytes"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hBAD;
            check($sformatf("%s_byte%0d", tag, i), got, 32'(exp_q[i]));
        end
    endtask

    task automatic run_xfer(input string tag, input logic [LEN_W-1:0] n,
                            input int exp_hs, input logic exp_under);
        int base;
        int cyc;
        cap_q.delete();
        hs_cnt  = 0;
        hs2_at  = -1;
        done_at = -1;
        base    = done_cnt;
        do_start(n);
        cyc = 0;
        while (done_cnt == base && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - base), 32'd1);
        check({tag, "_done_after_bytes"}, 32'(done_at), 32'(n));
        check_bytes(tag);
        check({tag, "_words_taken"}, 32'(hs_cnt), 32'(exp_hs));
        check({tag, "_underrun"}, {31'd0, underrun}, {31'd0, exp_under});
        check({tag, "_oe_end"}, {31'd0, ntr_oe}, 32'd0);
        check({tag, "_dout_end"}, {24'd0, ntr_dout}, 32'hFF);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        int cyc;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", {24'd0, ntr_dout}, 32'hFF);
        check("rst_oe", {31'd0, ntr_oe}, 32'd0);
        check("rst_ready", {31'd0, word_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single word, exactly len bytes
        src_q = '{32'h44332211};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_xfer("t1", 4, 1, 1'b0);

        // 2: two words, second prefetched before the first word is sent out
        src_q = '{32'h44332211, 32'h88776655};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_xfer("t2", 8, 2, 1'b0);
        check("t2_prefetch_early", 32'(hs2_at), 32'd0);

        // 3: second word never arrives
        src_q = '{32'h44332211};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_xfer("t3", 8, 1, 1'b1);

        // 4: len=5, trailing bytes discarded, no third word requested
        src_q = '{32'h44332211, 32'hDDCCBBAA, 32'h12345678};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        run_xfer("t4", 5, 2, 1'b0);
        check("t4_third_word_left", 32'(src_q.size()), 32'd1);
        src_q.delete();
        repeat (3) @(negedge clk);

        // 5a: zero-length response
        oe_seen = 1'b0;
        base    = done_cnt;
        do_start(0);
        check("t5a_done_next", {31'd0, done}, 32'd1);
        check("t5a_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t5a_done_one", {31'd0, done}, 32'd0);
        repeat (20) @(negedge clk);
        check("t5a_pulses", 32'(done_cnt - base), 32'd1);
        check("t5a_oe_never", {31'd0, oe_seen}, 32'd0);

        // 5b: abort after the second falling edge of a len=8 transfer
        src_q = '{32'h44332211, 32'h88776655};
        cap_q.delete();
        base = done_cnt;
        do_start(8);
        cyc = 0;
        while (cap_q.size() < 2 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge ntr_clk);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5b_busy", {31'd0, busy}, 32'd0);
        check("t5b_oe", {31'd0, ntr_oe}, 32'd0);
        check("t5b_dout", {24'd0, ntr_dout}, 32'hFF);
        repeat (200) @(negedge clk);
        check("t5b_no_done", 32'(done_cnt - base), 32'd0);
        check("t5b_nbytes", 32'(cap_q.size()), 32'd2);
        src_q.delete();

        // 6: asynchronous reset in the middle of DRIVE, then a clean transfer
        src_q = '{32'h44332211, 32'h88776655};
        cap_q.delete();
        do_start(8);
        cyc = 0;
        while (cap_q.size() < 2 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_pre_oe", {31'd0, ntr_oe}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_oe", {31'd0, ntr_oe}, 32'd0);
        check("t6_rst_dout", {24'd0, ntr_dout}, 32'hFF);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        src_q.delete();
        repeat (3) @(negedge clk);
        src_q = '{32'h44332211};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_xfer("t6b", 4, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
